uart_tx_arb: RTL and testbench

- Two-requester arbiter that shares the single UART transmit path (byte write port `w_data`/`wr_uart`, back-pressure `tx_full`) between two byte-stream sources.
- Grants are packet-locked: once granted, a requester keeps the transmitter until it sends a beat flagged `last`.
- Arbitration between packets is round-robin.
- A watchdog revokes a grant held by a requester that stalls mid-packet, so the other requester cannot be starved.

---
 rtl/uart_tx_arb.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester, packet-locked, round-robin arbiter in front of a UART TX byte port.
// A watchdog revokes a grant whose owner stalls mid-packet so the other side is not starved.
module uart_tx_arb #(
   parameter int DW      = 8,
   parameter int IDLE_TO = 64,
   parameter int TO_W    = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   input  logic          req0_last,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   input  logic          req1_last,
   output logic          req1_ready,
   input  logic          tx_full,
   output logic          wr_uart,
   output logic [DW-1:0] w_data,
   output logic [1:0]    grant,
   output logic          busy,
   output logic          timeout_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(IDLE_TO - 1);

   state_t          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            last_served_q, last_served_d;
   logic [TO_W-1:0] wdog_q, wdog_d;
   logic            wr_q, wr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            to_err_q, to_err_d;

   logic [1:0]      valid_v;
   logic [1:0]      last_v;
   logic [1:0]      ready_v;
   logic [1:0]      accept_v;
   logic            owner;
   logic            owner_valid;
   logic            owner_last;
   logic [DW-1:0]   owner_data;

   assign valid_v = {req1_valid, req0_valid};
   assign last_v  = {req1_last, req0_last};

   // The ~wr_q term guarantees an idle cycle after every write, hiding the UART full-flag lag.
   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign ready_v[gi]  = (state_q == GRANT) & grant_q[gi] & ~tx_full & ~wr_q;
      assign accept_v[gi] = valid_v[gi] & ready_v[gi];
   end

   // grant_q is one-hot in GRANT, so bit 1 alone identifies the owner.
   assign owner       = grant_q[1];
   assign owner_valid = valid_v[owner];
   assign owner_last  = last_v[owner];
   assign owner_data  = owner ? req1_data : req0_data;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_served_d = last_served_q;
      wdog_d        = wdog_q;
      wr_d          = 1'b0;
      wdata_d       = wdata_q;
      to_err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (|valid_v) begin
               state_d = GRANT;
               if (&valid_v) begin
                  grant_d = last_served_q ? 2'b01 : 2'b10;
               end else begin
                  grant_d = valid_v;
               end
            end
         end
         GRANT: begin
            if (|accept_v) begin
               wr_d    = 1'b1;
               wdata_d = owner_data;
               wdog_d  = '0;
               if (owner_last) begin
                  state_d       = IDLE;
                  grant_d       = 2'b00;
                  last_served_d = owner;
               end
            end else if (!owner_valid) begin
               // Only starvation counts; back-pressured cycles leave the watchdog alone.
               if (wdog_q >= TO_LIMIT) begin
                  state_d       = IDLE;
                  grant_d       = 2'b00;
                  last_served_d = owner;
                  wdog_d        = '0;
                  to_err_d      = 1'b1;
               end else begin
                  wdog_d = wdog_q + TO_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         grant_q       <= 2'b00;
         last_served_q <= 1'b1;
         wdog_q        <= '0;
         wr_q          <= 1'b0;
         wdata_q       <= '0;
         to_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_served_q <= last_served_d;
         wdog_q        <= wdog_d;
         wr_q          <= wr_d;
         wdata_q       <= wdata_d;
         to_err_q      <= to_err_d;
      end
   end

   assign req0_ready  = ready_v[0];
   assign req1_ready  = ready_v[1];
   assign wr_uart     = wr_q;
   assign w_data      = wdata_q;
   assign grant       = grant_q;
   assign busy        = (state_q == GRANT);
   assign timeout_err = to_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed packets plus randomized traffic, checked by a
// transaction-level arbiter model and a write-stream scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arb;
   localparam int DW      = 8;
   localparam int IDLE_TO = 8;
   localparam int TO_W    = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic          req0_last = 1'b0, req1_last = 1'b0;
   logic          req0_ready, req1_ready;
   logic          tx_full = 1'b0;
   logic          wr_uart;
   logic [DW-1:0] w_data;
   logic [1:0]    grant;
   logic          busy;
   logic          timeout_err;

   always #5 clk = ~clk;

   uart_tx_arb #(.DW(DW), .IDLE_TO(IDLE_TO), .TO_W(TO_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW:0]   src_q0[$];
   logic [DW:0]   src_q1[$];

   // Reference model: who owns the link, who was served last, how long the owner has starved.
   int            m_owner = -1;
   int            m_last  = 1;
   int            m_starve = 0;
   bit            m_wr = 1'b0;
   bit            m_to = 1'b0;
   logic [DW-1:0] m_wdata = '0;

   int  en_pct0 = 100, en_pct1 = 100, txf_pct = 0;
   bit  txf_force = 1'b0;
   bit  rst_done = 1'b0;
   int  cyc = 0;

   task automatic step(input bit rst_now, input bit rst_on_acc);
      bit            v [2];
      bit            l [2];
      logic [DW-1:0] d [2];
      bit            er [2];
      bit            acc [2];
      bit            txf, do_rst, nwr, nto;
      logic [1:0]    eg;
      logic [6:0]    got, expv;
      @(posedge clk);
      #1;
      cyc++;
      v[0] = (src_q0.size() > 0) && ($urandom_range(99) < en_pct0);
      v[1] = (src_q1.size() > 0) && ($urandom_range(99) < en_pct1);
      if (v[0]) {l[0], d[0]} = src_q0[0]; else begin l[0] = 1'($urandom); d[0] = DW'($urandom); end
      if (v[1]) {l[1], d[1]} = src_q1[0]; else begin l[1] = 1'($urandom); d[1] = DW'($urandom); end
      txf = txf_force || ($urandom_range(99) < txf_pct);
      req0_valid = v[0]; req0_last = l[0]; req0_data = d[0];
      req1_valid = v[1]; req1_last = l[1]; req1_data = d[1];
      tx_full = txf;
      for (int n = 0; n < 2; n++) begin
         er[n]  = (m_owner == n) && !txf && !m_wr;
         acc[n] = v[n] && er[n];
      end
      do_rst = rst_now || (rst_on_acc && (acc[0] || acc[1]));
      reset_n = !do_rst;
      @(negedge clk);
      eg   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      expv = {er[1], er[0], eg, (m_owner >= 0), m_wr, m_to};
      got  = {req1_ready, req0_ready, grant, busy, wr_uart, timeout_err};
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL ctrl cyc=%0d {rdy1,rdy0,grant,busy,wr,to} got=%b exp=%b", cyc, got, expv);
      end
      if (!m_wr) begin
         n_cmp++;
         if (w_data !== m_wdata) begin
            n_err++;
            $display("FAIL w_data_hold cyc=%0d got=%h exp=%h", cyc, w_data, m_wdata);
         end
      end
      nwr = 1'b0;
      nto = 1'b0;
      if (do_rst) begin
         // A handshake coincident with reset is seen by the source but never reaches the UART.
         if (acc[0]) void'(src_q0.pop_front());
         if (acc[1]) void'(src_q1.pop_front());
         m_owner = -1; m_last = 1; m_starve = 0; m_wdata = '0;
         rst_done = 1'b1;
      end else if (m_owner < 0) begin
         if (v[0] && v[1]) m_owner = 1 - m_last;
         else if (v[0])    m_owner = 0;
         else if (v[1])    m_owner = 1;
      end else begin
         int n;
         n = m_owner;
         if (acc[n]) begin
            exp_q.push_back(d[n]);
            nwr = 1'b1;
            m_wdata = d[n];
            m_starve = 0;
            if (n == 0) void'(src_q0.pop_front()); else void'(src_q1.pop_front());
            if (l[n]) begin
               m_last = n;
               m_owner = -1;
            end
         end else if (!v[n]) begin
            m_starve++;
            if (m_starve == IDLE_TO) begin
               nto = 1'b1;
               m_owner = -1;
               m_last = n;
               m_starve = 0;
            end
         end
      end
      m_wr = nwr;
      m_to = nto;
   endtask

   task automatic drain(input int max_cyc, input string tag);
      int k;
      k = 0;
      while ((src_q0.size() > 0 || src_q1.size() > 0 || m_owner >= 0 || m_wr) && k < max_cyc) begin
         step(1'b0, 1'b0);
         k++;
      end
      step(1'b0, 1'b0);
      n_cmp++;
      if (k >= max_cyc) begin
         n_err++;
         $display("FAIL drain_%s did not complete in %0d cycles, left q0=%0d q1=%0d", tag, max_cyc, src_q0.size(), src_q1.size());
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
   endtask

   // Scoreboard: every UART write must be the next byte the model accepted, and never back-to-back.
   bit prev_wr = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (wr_uart === 1'b1) begin
            n_cmp++;
            if (prev_wr) begin
               n_err++;
               $display("FAIL wr_adjacent t=%0t got=two consecutive strobes exp=gap", $time);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL wr_unexpected t=%0t got=%h exp=no write", $time, w_data);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (w_data !== e) begin
                  n_err++;
                  $display("FAIL wr_data t=%0t got=%h exp=%h", $time, w_data, e);
               end else begin
                  $display("write t=%0t w_data=%h", $time, w_data);
               end
            end
         end
         prev_wr = (wr_uart === 1'b1);
      end
   end

   logic [6:0] seq0 = '0, seq1 = '0;

   initial begin
      int k;
      do_reset(3);

      // Single 3-byte packet from req0.
      src_q0.push_back({1'b0, 8'h41});
      src_q0.push_back({1'b0, 8'h42});
      src_q0.push_back({1'b1, 8'h43});
      drain(50, "single");

      // Contest out of reset, then again: round-robin should flip the winner.
      do_reset(2);
      for (int r = 0; r < 2; r++) begin
         src_q0.push_back({1'b0, 8'hA0});
         src_q0.push_back({1'b1, 8'hA1});
         src_q1.push_back({1'b0, 8'hB0});
         src_q1.push_back({1'b1, 8'hB1});
         drain(60, "contest");
      end

      // Back-pressure on req1 longer than the watchdog limit must not revoke the grant.
      src_q1.push_back({1'b0, 8'hC0});
      src_q1.push_back({1'b1, 8'hC1});
      k = 0;
      while (m_owner != 1 && k < 10) begin step(1'b0, 1'b0); k++; end
      txf_force = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      txf_force = 1'b0;
      drain(40, "txfull");

      // Stall mid-packet: watchdog fires, then the waiting req1 is served.
      src_q0.push_back({1'b0, 8'hD0});
      k = 0;
      while (src_q0.size() > 0 && k < 10) begin step(1'b0, 1'b0); k++; end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      src_q1.push_back({1'b1, 8'hE0});
      drain(40, "timeout");

      // Reset landing on an accept mid-packet.
      src_q0.push_back({1'b0, 8'hF0});
      src_q0.push_back({1'b0, 8'hF1});
      src_q0.push_back({1'b1, 8'hF2});
      k = 0;
      while (src_q0.size() > 2 && k < 10) begin step(1'b0, 1'b0); k++; end
      rst_done = 1'b0;
      k = 0;
      while (!rst_done && k < 10) begin step(1'b0, 1'b1); k++; end
      n_cmp++;
      if (!rst_done) begin
         n_err++;
         $display("FAIL reset_on_accept got=no accept seen exp=accept within 10 cycles");
      end
      drain(40, "reset");

      // Random traffic with stalls, back-pressure and varying offered load.
      txf_pct = 25;
      for (int c = 0; c < 10000; c++) begin
         if (c % 200 == 0) begin
            en_pct0 = ($urandom_range(3) == 0) ? 0 : 40 + $urandom_range(60);
            en_pct1 = ($urandom_range(3) == 0) ? 0 : 40 + $urandom_range(60);
         end
         if (src_q0.size() == 0 && $urandom_range(7) == 0) begin
            int len;
            len = 1 + $urandom_range(3);
            for (int b = 0; b < len; b++) begin
               src_q0.push_back({(b == len - 1), 1'b0, seq0});
               seq0++;
            end
         end
         if (src_q1.size() == 0 && $urandom_range(7) == 0) begin
            int len;
            len = 1 + $urandom_range(3);
            for (int b = 0; b < len; b++) begin
               src_q1.push_back({(b == len - 1), 1'b1, seq1});
               seq1++;
            end
         end
         step(1'b0, 1'b0);
      end
      en_pct0 = 100; en_pct1 = 100; txf_pct = 0;
      drain(300, "stress");
      step(1'b0, 1'b0);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_writes got=%0d pending exp=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
